// File: rtl/psum_drain_collector.sv
// South-edge collector: de-skews bottom-row psum lanes into aligned rows, buffers them
// in a show-ahead FIFO and writes them to the output SRAM. Optional macro DRAIN_RELU_EN.
module psum_drain_collector #(
   parameter int COLS       = 4,
   parameter int A_W        = 24,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W-1:0]     num_rows,
   input  logic [COLS*A_W-1:0]   psum_in,
   input  logic [COLS-1:0]       psum_vld,
   output logic                  mem_we,
   input  logic                  mem_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [COLS*A_W-1:0]   mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf_err,
   output logic                  skew_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int DW = COLS * A_W;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_num;
   logic [ADDR_W-1:0]   r_push_cnt;
   logic [ADDR_W-1:0]   r_wr_cnt;
   logic [ADDR_W-1:0]   r_drop_cnt;
   logic                r_ovf_err;
   logic                r_skew_err;
   logic [PW:0]         r_wptr;
   logic [PW:0]         r_rptr;
   logic [DW-1:0]       r_fifo [FIFO_DEPTH];
   logic [DW-1:0]       r_cap_data;
   logic [COLS-1:0]     r_cap_vld;

   logic [A_W-1:0]      w_lane_d [COLS];
   logic [COLS-1:0]     w_vld_d;
   logic [DW-1:0]       w_push_data;
   logic                w_empty, w_full;
   logic                w_row_full, w_row_mixed;
   logic                w_take, w_push, w_drop, w_we, w_wr, w_last;
   logic [ADDR_W:0]     w_retired;

   // Lane j waits COLS-1-j cycles so every lane of a row lands in the capture register together.
   for (genvar j = 0; j < COLS; j++) begin : g_lane
      localparam int D = COLS - 1 - j;
      if (D == 0) begin : g_direct
         assign w_lane_d[j] = psum_in[j*A_W +: A_W];
         assign w_vld_d[j]  = psum_vld[j];
      end else begin : g_dly
         logic [A_W-1:0] r_d [D];
         logic [D-1:0]   r_v;
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < D; k++) r_d[k] <= '0;
               r_v <= '0;
            end else begin
               r_d[0] <= psum_in[j*A_W +: A_W];
               r_v[0] <= psum_vld[j];
               for (int k = 1; k < D; k++) begin
                  r_d[k] <= r_d[k-1];
                  r_v[k] <= r_v[k-1];
               end
            end
         end
         assign w_lane_d[j] = r_d[D-1];
         assign w_vld_d[j]  = r_v[D-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cap_data <= '0;
         r_cap_vld  <= '0;
      end else begin
         r_cap_vld <= w_vld_d;
         for (int j = 0; j < COLS; j++) r_cap_data[j*A_W +: A_W] <= w_lane_d[j];
      end
   end

   // NOTE: every variable driven here gets a default first, so no latch can be inferred.
   always_comb begin
      w_push_data = r_cap_data;
`ifdef DRAIN_RELU_EN
      for (int j = 0; j < COLS; j++)
         if (r_cap_data[j*A_W + A_W - 1]) w_push_data[j*A_W +: A_W] = '0;
`endif
   end

   assign w_empty     = (r_wptr == r_rptr);
   assign w_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_row_full  = &r_cap_vld;
   assign w_row_mixed = (|r_cap_vld) && !w_row_full;

   // A row counts toward num_rows whether it is stored or dropped on a full FIFO.
   assign w_take    = (r_state == S_DRAIN) && w_row_full && (r_push_cnt < r_num);
   assign w_push    = w_take && !w_full;
   assign w_drop    = w_take && w_full;
   assign w_we      = (r_state == S_DRAIN) && !w_empty;
   assign w_wr      = w_we && mem_ready;
   assign w_retired = (ADDR_W+1)'(r_wr_cnt) + (ADDR_W+1)'(r_drop_cnt)
                    + (ADDR_W+1)'(w_drop) + (ADDR_W+1)'(1);
   assign w_last    = w_wr && (w_retired == {1'b0, r_num});

   // NOTE: FIFO storage has no reset; the pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr[PW-1:0]] <= w_push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_num      <= '0;
         r_push_cnt <= '0;
         r_wr_cnt   <= '0;
         r_drop_cnt <= '0;
         r_ovf_err  <= 1'b0;
         r_skew_err <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_wr)   r_rptr <= r_rptr + 1'b1;
         if (w_row_mixed) r_skew_err <= 1'b1;
         unique case (r_state)
            S_IDLE: if (start) begin
               r_base     <= base_addr;
               r_num      <= num_rows;
               r_push_cnt <= '0;
               r_wr_cnt   <= '0;
               r_drop_cnt <= '0;
               r_ovf_err  <= 1'b0;
               r_skew_err <= 1'b0;
               r_state    <= (num_rows == '0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
               if (w_take) r_push_cnt <= r_push_cnt + 1'b1;
               if (w_drop) begin
                  r_drop_cnt <= r_drop_cnt + 1'b1;
                  r_ovf_err  <= 1'b1;
               end
               if (w_wr)   r_wr_cnt <= r_wr_cnt + 1'b1;
               if (w_last) r_state  <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_we    = w_we;
   assign mem_addr  = r_base + r_wr_cnt;
   assign mem_wdata = w_we ? r_fifo[r_rptr[PW-1:0]] : '0;
   assign busy      = (r_state == S_DRAIN);
   assign done      = (r_state == S_DONE);
   assign ovf_err   = r_ovf_err;
   assign skew_err  = r_skew_err;

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed bench for psum_drain_collector: skewed row feeder, write-port scoreboard,
// and checks for alignment latency, stalls, overflow, skew, reset abort and DRAIN_RELU_EN.
module tb_psum_drain_collector;
   localparam int COLS = 4, A_W = 24, ADDR_W = 10, DEPTH = 4, DW = COLS * A_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr, num_rows;
   logic [DW-1:0]     psum_in;
   logic [COLS-1:0]   psum_vld;
   logic              mem_we, mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              busy, done, ovf_err, skew_err;

   psum_drain_collector #(.COLS(COLS), .A_W(A_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .psum_in(psum_in), .psum_vld(psum_vld), .mem_we(mem_we), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .ovf_err(ovf_err), .skew_err(skew_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DW-1:0]     data;
   } wr_t;

   wr_t               sb[$];
   wr_t               mon_e;
   int                n_checks = 0, n_errors = 0;
   int                cyc = 0, wr_cnt = 0, done_cnt = 0, first_we_cyc = -1, feed_start_cyc = 0;
   int                exp_left = 0, f_n = 0;
   logic [ADDR_W-1:0] exp_addr;
   logic [DW-1:0]     f_data [8];
   logic [COLS-1:0]   f_vld [8];
   logic [DW-1:0]     last_wdata = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
      model = d;
`ifdef DRAIN_RELU_EN
      for (int j = 0; j < COLS; j++)
         if (d[j*A_W + A_W - 1]) model[j*A_W +: A_W] = '0;
`endif
   endfunction

   // Write-port monitor: samples mid-cycle, the accept happens at the following rising edge.
   always begin
      @(negedge clk);
      #2;
      if (rst && done) done_cnt++;
      if (rst && mem_we && first_we_cyc < 0) first_we_cyc = cyc;
      if (rst && mem_we && mem_ready) begin
         wr_cnt++;
         last_wdata = mem_wdata;
         chk("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("wr_addr", mem_addr, mon_e.addr);
            chk("wr_data", mem_wdata, mon_e.data);
         end
      end
   end

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
      @(negedge clk);
      base_addr = b;
      num_rows  = n;
      start     = 1'b1;
      exp_addr  = b;
      exp_left  = int'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives f_data/f_vld rows with lane j delayed j cycles; expected writes are queued up front.
   task automatic feed();
      wr_t e;
      for (int r = 0; r < f_n; r++) begin
         if (&f_vld[r] && exp_left > 0) begin
            e.addr = exp_addr;
            e.data = model(f_data[r]);
            sb.push_back(e);
            exp_addr++;
            exp_left--;
         end
      end
      for (int c = 0; c < f_n + COLS - 1; c++) begin
         @(negedge clk);
         if (c == 0) feed_start_cyc = cyc;
         for (int j = 0; j < COLS; j++) begin
            int r;
            r = c - j;
            if (r >= 0 && r < f_n) begin
               psum_in[j*A_W +: A_W] = f_data[r][j*A_W +: A_W];
               psum_vld[j]           = f_vld[r][j];
            end else begin
               psum_in[j*A_W +: A_W] = '0;
               psum_vld[j]           = 1'b0;
            end
         end
      end
      @(negedge clk);
      psum_in  = '0;
      psum_vld = '0;
   endtask

   task automatic wait_done(input string tag);
      int d0, k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < 300) begin
         @(negedge clk);
         #3;
         k++;
      end
      chk({tag, "_done_seen"}, done_cnt != d0, 1'b1);
      repeat (3) begin
         @(negedge clk);
         #3;
      end
      chk({tag, "_done_once"}, done_cnt, d0 + 1);
      chk({tag, "_busy_low"}, busy, 1'b0);
      chk({tag, "_sb_drained"}, sb.size(), 0);
   endtask

   initial begin : stim
      int w0, d0;
      logic [DW-1:0] hold_data;
      logic [23:0]   exp_l0;
      rst = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
      psum_in = '0; psum_vld = '0; mem_ready = 1'b0;
      for (int r = 0; r < 8; r++) begin
         f_data[r] = {$urandom, $urandom, $urandom};
         f_vld[r]  = '1;
      end
      #12;
      chk("reset_outputs", {mem_we, mem_addr, mem_wdata, busy, done, ovf_err, skew_err}, '0);
      @(negedge clk);
      rst = 1'b1;

      // Basic drain with SRAM always ready; checks alignment latency.
      mem_ready = 1'b1;
      first_we_cyc = -1;
      w0 = wr_cnt;
      do_start(10'h010, 10'd3);
      #3;
      chk("t1_busy", busy, 1'b1);
      f_n = 3;
      feed();
      wait_done("t1");
      chk("t1_we_latency", first_we_cyc, feed_start_cyc + 5);
      chk("t1_writes", wr_cnt - w0, 3);

      // Stalled SRAM: head must hold steady, then drain in order.
      mem_ready = 1'b0;
      w0 = wr_cnt;
      do_start(10'h020, 10'd3);
      feed();
      repeat (2) @(negedge clk);
      #3;
      hold_data = model(f_data[0]);
      chk("t2_stall_we", mem_we, 1'b1);
      chk("t2_stall_addr", mem_addr, 10'h020);
      chk("t2_stall_data", mem_wdata, hold_data);
      repeat (3) @(negedge clk);
      #3;
      chk("t2_hold_addr", mem_addr, 10'h020);
      chk("t2_hold_data", mem_wdata, hold_data);
      @(negedge clk);
      mem_ready = 1'b1;
      wait_done("t2");
      chk("t2_ovf", ovf_err, 1'b0);
      chk("t2_writes", wr_cnt - w0, 3);

      // Overflow: six rows into a four-deep FIFO with no drain.
      mem_ready = 1'b0;
      w0 = wr_cnt;
      do_start(10'h100, 10'd6);
      exp_left = 4;
      f_n = 6;
      feed();
      repeat (3) @(negedge clk);
      #3;
      chk("t3_ovf", ovf_err, 1'b1);
      chk("t3_busy", busy, 1'b1);
      @(negedge clk);
      mem_ready = 1'b1;
      wait_done("t3");
      chk("t3_writes", wr_cnt - w0, 4);

      // Partially valid row: discarded, skew_err sticky until the next start.
      w0 = wr_cnt;
      do_start(10'h040, 10'd1);
      f_n = 1;
      f_vld[0] = 4'b1011;
      feed();
      repeat (2) @(negedge clk);
      #3;
      chk("t4_skew", skew_err, 1'b1);
      chk("t4_no_write", wr_cnt - w0, 0);
      chk("t4_busy", busy, 1'b1);
      f_vld[0] = 4'hF;
      feed();
      wait_done("t4");
      chk("t4_skew_sticky", skew_err, 1'b1);
      d0 = done_cnt;
      w0 = wr_cnt;
      do_start(10'h000, 10'd0);
      #3;
      chk("t4_zero_done", done, 1'b1);
      chk("t4_skew_clear", skew_err, 1'b0);
      @(negedge clk);
      #3;
      chk("t4_zero_done_end", done, 1'b0);
      chk("t4_zero_pulses", done_cnt, d0 + 1);

      // Reset mid-drain after one write.
      mem_ready = 1'b0;
      for (int r = 0; r < 3; r++) f_data[r] = {$urandom, $urandom, $urandom};
      w0 = wr_cnt;
      do_start(10'h080, 10'd3);
      f_n = 3;
      feed();
      repeat (2) @(negedge clk);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk("t5_async_reset", {mem_we, mem_addr, mem_wdata, busy, done, ovf_err, skew_err}, '0);
      chk("t5_one_write", wr_cnt - w0, 1);
      sb.delete();
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      #3;
      chk("t5_no_done", done_cnt, d0);
      @(negedge clk);
      rst = 1'b1;
      w0 = wr_cnt;
      do_start(10'h0AA, 10'd0);
      #3;
      chk("t5_zero_done", done, 1'b1);
      repeat (2) @(negedge clk);
      #3;
      chk("t5_zero_pulses", done_cnt, d0 + 1);
      chk("t5_zero_writes", wr_cnt - w0, 0);

      // Sign handling of lane values (ReLU only when DRAIN_RELU_EN is defined).
      mem_ready = 1'b1;
      f_data[0] = {24'h7FFFFF, 24'h800000, 24'h000005, 24'hFFFFF0};
      f_vld[0]  = 4'hF;
      w0 = wr_cnt;
      do_start(10'h200, 10'd1);
      f_n = 1;
      feed();
      wait_done("t6");
`ifdef DRAIN_RELU_EN
      exp_l0 = 24'h000000;
`else
      exp_l0 = 24'hFFFFF0;
`endif
      chk("t6_writes", wr_cnt - w0, 1);
      chk("t6_lane0", last_wdata[23:0], exp_l0);
      chk("t6_lane1", last_wdata[47:24], 24'h000005);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
